// File: rtl/display_pkg.sv
// Shared constants and helpers for the 7-segment display path.
package display_pkg;

  localparam int unsigned NUM_DIGITS_DEFAULT = 6;

  // Active-high segment patterns, bit order {g,f,e,d,c,b,a}.
  localparam logic [6:0] SEG_0    = 7'h3F;
  localparam logic [6:0] SEG_1    = 7'h06;
  localparam logic [6:0] SEG_2    = 7'h5B;
  localparam logic [6:0] SEG_3    = 7'h4F;
  localparam logic [6:0] SEG_4    = 7'h66;
  localparam logic [6:0] SEG_5    = 7'h6D;
  localparam logic [6:0] SEG_6    = 7'h7D;
  localparam logic [6:0] SEG_7    = 7'h07;
  localparam logic [6:0] SEG_8    = 7'h7F;
  localparam logic [6:0] SEG_9    = 7'h6F;
  localparam logic [6:0] SEG_DASH = 7'h40;
  localparam logic [6:0] SEG_OFF  = 7'h00;

  // Map an active-high pattern onto the pin polarity.
  function automatic logic [6:0] seg_polarity(input logic [6:0] seg, input logic active_low);
    return active_low ? ~seg : seg;
  endfunction

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD nibble to active-high 7-segment decoder with blanking.
module bcd_to_seg7
  import display_pkg::*;
(
  input  logic [3:0] nibble_i,
  input  logic       blank_i,
  output logic [6:0] seg_o
);

  // Blank wins over the value; non-decimal nibbles show a dash.
  always_comb begin
    seg_o = SEG_DASH;
    if (blank_i) begin
      seg_o = SEG_OFF;
    end else begin
      case (nibble_i)
        4'd0:    seg_o = SEG_0;
        4'd1:    seg_o = SEG_1;
        4'd2:    seg_o = SEG_2;
        4'd3:    seg_o = SEG_3;
        4'd4:    seg_o = SEG_4;
        4'd5:    seg_o = SEG_5;
        4'd6:    seg_o = SEG_6;
        4'd7:    seg_o = SEG_7;
        4'd8:    seg_o = SEG_8;
        4'd9:    seg_o = SEG_9;
        default: seg_o = SEG_DASH;
      endcase
    end
  end

endmodule

// File: rtl/bcd_display_scanner.sv
// Time-multiplexed common-anode 7-segment scanner: per-frame snapshot, one dark cycle per
// digit slot, optional leading-zero blanking.
module bcd_display_scanner
  import display_pkg::*;
#(
  parameter int unsigned NUM_DIGITS     = NUM_DIGITS_DEFAULT,
  parameter int unsigned SCAN_DIV       = 1000,
  parameter int unsigned ACTIVE_LOW_SEG = 1
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] io_bcd,
  input  logic                    io_blank_en,
  output logic [6:0]              io_seg,
  output logic [NUM_DIGITS-1:0]   io_an,
  output logic                    io_frame
);

  localparam int unsigned PreW = $clog2(SCAN_DIV);
  localparam int unsigned IdxW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [PreW-1:0] PreLast = PreW'(SCAN_DIV - 1);
  localparam logic [IdxW-1:0] IdxLast = IdxW'(NUM_DIGITS - 1);
  localparam logic            SegActiveLow = (ACTIVE_LOW_SEG != 0);
  localparam logic [6:0]      SegDark = seg_polarity(SEG_OFF, SegActiveLow);

  logic [PreW-1:0]         pre_q, pre_d;
  logic [IdxW-1:0]         idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] snap_q, snap_d;
  logic                    blank_snap_q, blank_snap_d;
  logic                    frame_q, frame_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic [6:0]              seg_q, seg_d;

  logic                    frame_start;
  logic                    lead_zero;
  logic [NUM_DIGITS-1:0]   blank_mask;
  logic [3:0]              cur_nibble;
  logic                    cur_blank;
  logic [6:0]              seg_raw;

  // Leading-zero mask: digit i is blanked while every digit from the top down to i is zero.
  always_comb begin
    lead_zero  = 1'b1;
    blank_mask = '0;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      lead_zero     = lead_zero & (snap_q[4*i +: 4] == 4'h0);
      blank_mask[i] = blank_snap_q & lead_zero;
    end
  end

  // Select the snapshot nibble and blank flag of the digit in the current slot.
  always_comb begin
    cur_nibble = 4'h0;
    cur_blank  = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_q == IdxW'(i)) begin
        cur_nibble = snap_q[4*i +: 4];
        cur_blank  = blank_mask[i];
      end
    end
  end

  bcd_to_seg7 u_decode (
    .nibble_i (cur_nibble),
    .blank_i  (cur_blank),
    .seg_o    (seg_raw)
  );

  // Next-state for prescaler, digit index, snapshot and registered pins.
  always_comb begin
    frame_start  = (pre_q == '0) && (idx_q == '0);
    pre_d        = (pre_q == PreLast) ? '0 : pre_q + PreW'(1);
    idx_d        = idx_q;
    if (pre_q == PreLast) begin
      idx_d = (idx_q == IdxLast) ? '0 : idx_q + IdxW'(1);
    end
    snap_d       = snap_q;
    blank_snap_d = blank_snap_q;
    if (frame_start) begin
      snap_d       = io_bcd;
      blank_snap_d = io_blank_en;
    end
    frame_d = frame_start;
    // First cycle of each slot is dark; it also hides the snapshot update.
    an_d    = '1;
    seg_d   = SegDark;
    if (pre_q != '0) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        an_d[i] = (idx_q != IdxW'(i));
      end
      seg_d = seg_polarity(seg_raw, SegActiveLow);
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      pre_q        <= '0;
      idx_q        <= '0;
      snap_q       <= '0;
      blank_snap_q <= 1'b0;
      frame_q      <= 1'b0;
      an_q         <= '1;
      seg_q        <= SegDark;
    end else begin
      pre_q        <= pre_d;
      idx_q        <= idx_d;
      snap_q       <= snap_d;
      blank_snap_q <= blank_snap_d;
      frame_q      <= frame_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
    end
  end

  assign io_seg   = seg_q;
  assign io_an    = an_q;
  assign io_frame = frame_q;

endmodule
